morse_tx_sched: RTL and testbench

MORSE_TX_SCHED -- requirements
Module: morse_tx_sched

---
 rtl/morse_pkg.sv | 16 +
 rtl/morse_char_fifo.sv | 64 ++++++
 rtl/morse_tx_sched.sv | 158 +++++++++++++++
 tb/tb_morse_tx_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse character scheduler.
package morse_pkg;

  localparam int CODE_W       = 5;
  localparam int MAX_LETTER   = 25;
  localparam int UNIT_CYC     = 99;
  localparam int CHAR_GAP_DEF = 3 * UNIT_CYC;
  localparam int WORD_GAP_DEF = 7 * UNIT_CYC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XMIT = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/morse_char_fifo.sv
// Synchronous character queue with push, pop, flush and occupancy.
// head_vld is asserted only once an entry has been visible for a full cycle.
// This gives one cycle of head presentation latency, so an entry written into
// an empty queue is never popped on the very next edge.
module morse_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty,
  output logic                     head_vld
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             seen_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (fill == (AW+1)'(DEPTH));
  assign empty    = (fill == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rdata    = mem[rd_ptr];
  assign head_vld = seen_q && !empty;

  // Storage write; contents need no reset because fill gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and head-presentation flag; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      seen_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      seen_q <= !empty;
    end
  end

endmodule

// File: rtl/morse_tx_sched.sv
// Morse character scheduler: queues letter codes and hands them one at a
// time to the element generator, then enforces the inter-character gap.
// Optional feature macro: MORSE_TX_SCHED_WORD_GAP_EN (space entries become
// word gaps instead of being sent as letters).
//
// state | meaning
// IDLE  | waiting for a presented queue head; pops and dispatches it
// XMIT  | key_en high, generator sending key_sel; waits for key_done
// GAP   | key_en low, down-counting the gap to terminal count 0
module morse_tx_sched
  import morse_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CHAR_GAP   = CHAR_GAP_DEF,
  parameter int WORD_GAP   = WORD_GAP_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CODE_W-1:0]             in_char,
  input  logic                          in_space,
  output logic                          key_en,
  output logic [CODE_W-1:0]             key_sel,
  input  logic                          key_done,
  output logic                          busy,
  output logic                          err,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int GAP_MAX = (WORD_GAP > CHAR_GAP) ? WORD_GAP : CHAR_GAP;
  localparam int CW      = $clog2(GAP_MAX) + 1;
`ifdef MORSE_TX_SCHED_WORD_GAP_EN
  localparam int ENT_W   = CODE_W + 1;
`else
  localparam int ENT_W   = CODE_W;
`endif

  tx_state_t        state, state_n;
  logic             key_en_n;
  logic [CODE_W-1:0] key_sel_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             err_n;

  logic             q_full;
  logic             q_empty;
  logic             q_head_vld;
  logic             q_push;
  logic             q_pop;
  logic [ENT_W-1:0] q_wdata;
  logic [ENT_W-1:0] q_rdata;
  logic [CODE_W-1:0] head_char;
  logic             head_space;

  assign in_ready = !q_full && !rst && !flush;
  assign q_push   = in_valid && in_ready;
  assign busy     = (fill != '0) || (state != ST_IDLE);
  assign head_char = q_rdata[CODE_W-1:0];

`ifdef MORSE_TX_SCHED_WORD_GAP_EN
  assign q_wdata    = {in_space, in_char};
  assign head_space = q_rdata[CODE_W];
`else
  logic unused_space;
  assign unused_space = in_space;
  assign q_wdata      = in_char;
  assign head_space   = 1'b0;
`endif

  morse_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (q_push),
    .pop      (q_pop),
    .wdata    (q_wdata),
    .rdata    (q_rdata),
    .fill     (fill),
    .full     (q_full),
    .empty    (q_empty),
    .head_vld (q_head_vld)
  );

  // State, key outputs, gap counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      key_en  <= 1'b0;
      key_sel <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      key_en  <= key_en_n;
      key_sel <= key_sel_n;
      cnt     <= cnt_n;
      err     <= err_n;
    end
  end

  // Next-state logic; flush overrides everything, key_done only matters in XMIT.
  always_comb begin
    state_n   = state;
    key_en_n  = key_en;
    key_sel_n = key_sel;
    cnt_n     = cnt;
    err_n     = err;
    q_pop     = 1'b0;
    if (flush) begin
      state_n  = ST_IDLE;
      key_en_n = 1'b0;
      cnt_n    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (q_head_vld) begin
            q_pop = 1'b1;
            if (head_space) begin
              cnt_n   = CW'(WORD_GAP - 1);
              state_n = ST_GAP;
            end else if (head_char > CODE_W'(MAX_LETTER)) begin
              // Bad codes are dropped with no air time and no gap.
              err_n = 1'b1;
            end else begin
              key_sel_n = head_char;
              key_en_n  = 1'b1;
              state_n   = ST_XMIT;
            end
          end
        end
        ST_XMIT: begin
          if (key_done) begin
            key_en_n = 1'b0;
            cnt_n    = CW'(CHAR_GAP - 1);
            state_n  = ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: begin
          state_n  = ST_IDLE;
          key_en_n = 1'b0;
          cnt_n    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_sched.sv
// Directed-plus-random bench for morse_tx_sched. Expected letters come from a
// queue model; expected timing from gap arithmetic (gap cycles plus the one
// IDLE cycle in which the next entry is popped).
module tb_morse_tx_sched;

  localparam int CG     = 297;
  localparam int WG     = 693;
  localparam int BUDGET = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_char;
  logic       in_space;
  logic       key_en;
  logic [4:0] key_sel;
  logic       key_done;
  logic       busy;
  logic       err;
  logic [2:0] fill;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  morse_tx_sched dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .in_space (in_space),
    .key_en   (key_en),
    .key_sel  (key_sel),
    .key_done (key_done),
    .busy     (busy),
    .err      (err),
    .fill     (fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] c, input logic sp);
    in_valid = 1'b1;
    in_char  = c;
    in_space = sp;
    tick();
    in_valid = 1'b0;
    in_space = 1'b0;
  endtask

  task automatic pulse_done();
    key_done = 1'b1;
    tick();
    key_done = 1'b0;
  endtask

  task automatic hold_random();
    repeat ($urandom_range(15, 1)) tick();
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (key_en !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < BUDGET) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] q[$];
    logic [4:0] r;
    logic [4:0] r2;
    logic [4:0] e;
    logic [4:0] sc;
    int n;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_space = 1'b0;
    in_char = '0; key_done = 1'b0;

    // reset values
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_key_en",   32'(key_en),   0);
    chk("rst_key_sel",  32'(key_sel),  0);
    chk("rst_fill",     32'(fill),     0);
    chk("rst_busy",     32'(busy),     0);
    chk("rst_err",      32'(err),      0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // single 'A': key_en on the second edge after the push, then a full char gap
    push(5'd0, 1'b0);
    chk("a_fill", 32'(fill), 1);
    chk("a_en_e0", 32'(key_en), 0);
    tick();
    chk("a_en_e1", 32'(key_en), 0);
    tick();
    chk("a_en_e2", 32'(key_en), 1);
    chk("a_sel", 32'(key_sel), 0);
    hold_random();
    chk("a_hold", 32'(key_en), 1);
    pulse_done();
    chk("a_en_fall", 32'(key_en), 0);
    chk("a_busy_gap", 32'(busy), 1);
    wait_idle(n);
    chk("a_gap_len", n, CG);

    // three random letters back to back
    for (int i = 0; i < 3; i++) begin
      r = 5'($urandom_range(25));
      q.push_back(r);
      chk("b_in_ready", 32'(in_ready), 1);
      push(r, 1'b0);
    end
    wait_rise(n);
    for (int i = 0; i < 3; i++) begin
      e = q.pop_front();
      chk("b_sel", 32'(key_sel), 32'(e));
      hold_random();
      chk("b_hold", 32'(key_en), 1);
      pulse_done();
      chk("b_en_fall", 32'(key_en), 0);
      if (i < 2) begin
        wait_rise(n);
        chk("b_low_len", n, CG + 1);
      end
    end
    wait_idle(n);
    chk("b_gap_len", n, CG);

    // fill the queue while transmission is stalled
    r = 5'($urandom_range(25));
    push(r, 1'b0);
    tick();
    tick();
    chk("c_xmit", 32'(key_en), 1);
    for (int i = 0; i < 4; i++) begin
      r2 = 5'($urandom_range(25));
      q.push_back(r2);
      chk("c_in_ready", 32'(in_ready), 1);
      push(r2, 1'b0);
    end
    chk("c_fill_full", 32'(fill), 4);
    chk("c_ready_low", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_char  = 5'($urandom_range(25));
    tick();
    in_valid = 1'b0;
    chk("c_fifth_rejected", 32'(fill), 4);
    chk("c_sel_stable", 32'(key_sel), 32'(r));
    pulse_done();
    wait_rise(n);
    chk("c_low_len", n, CG + 1);
    chk("c_fill_after_pop", 32'(fill), 3);
    chk("c_ready_back", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      e = q.pop_front();
      chk("c_sel", 32'(key_sel), 32'(e));
      pulse_done();
      if (i < 3) begin
        wait_rise(n);
        chk("c_low_len2", n, CG + 1);
      end
    end
    wait_idle(n);
    chk("c_gap_len", n, CG);

    // out-of-range code is dropped, following letter goes out at once
    r2 = 5'($urandom_range(31, 26));
    r  = 5'($urandom_range(25));
    push(r2, 1'b0);
    push(r, 1'b0);
    chk("d_err_pre", 32'(err), 0);
    tick();
    chk("d_err_set", 32'(err), 1);
    chk("d_no_xmit", 32'(key_en), 0);
    chk("d_fill", 32'(fill), 1);
    tick();
    chk("d_immediate", 32'(key_en), 1);
    chk("d_sel", 32'(key_sel), 32'(r));
    pulse_done();
    wait_idle(n);
    chk("d_gap_len", n, CG);
    chk("d_err_sticky", 32'(err), 1);

    // 'T', space, 'T'
    sc = 5'($urandom_range(25));
    push(5'd19, 1'b0);
    push(sc, 1'b1);
    push(5'd19, 1'b0);
    chk("e_first_en", 32'(key_en), 1);
    chk("e_first_sel", 32'(key_sel), 19);
    pulse_done();
`ifdef MORSE_TX_SCHED_WORD_GAP_EN
    wait_rise(n);
    chk("e_word_gap", n, CG + 1 + WG + 1);
    chk("e_second_sel", 32'(key_sel), 19);
`else
    wait_rise(n);
    chk("e_low_len", n, CG + 1);
    chk("e_space_as_letter", 32'(key_sel), 32'(sc));
    pulse_done();
    wait_rise(n);
    chk("e_low_len2", n, CG + 1);
    chk("e_second_sel", 32'(key_sel), 19);
`endif
    pulse_done();
    wait_idle(n);
    chk("e_gap_len", n, CG);

    // flush during XMIT with two entries queued
    r = 5'($urandom_range(25));
    push(r, 1'b0);
    tick();
    tick();
    chk("f_xmit", 32'(key_en), 1);
    push(5'($urandom_range(25)), 1'b0);
    push(5'($urandom_range(25)), 1'b0);
    chk("f_fill", 32'(fill), 2);
    flush = 1'b1;
    #1;
    chk("f_ready_low", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    chk("f_key_en", 32'(key_en), 0);
    chk("f_fill0", 32'(fill), 0);
    chk("f_idle", 32'(busy), 0);
    pulse_done();
    repeat (3) tick();
    chk("f_done_ignored_en", 32'(key_en), 0);
    chk("f_done_ignored_busy", 32'(busy), 0);

    // reset in the middle of GAP, with a coincident key_done
    r = 5'($urandom_range(25));
    push(r, 1'b0);
    tick();
    tick();
    chk("g_xmit", 32'(key_en), 1);
    pulse_done();
    repeat ($urandom_range(100, 5)) tick();
    chk("g_in_gap", 32'(busy), 1);
    r2 = 5'($urandom_range(25));
    push(r2, 1'b0);
    chk("g_fill", 32'(fill), 1);
    rst = 1'b1;
    key_done = 1'b1;
    #1;
    chk("g_ready_in_rst", 32'(in_ready), 0);
    tick();
    key_done = 1'b0;
    chk("g_key_en",  32'(key_en),  0);
    chk("g_key_sel", 32'(key_sel), 0);
    chk("g_fill0",   32'(fill),    0);
    chk("g_busy",    32'(busy),    0);
    chk("g_err",     32'(err),     0);
    rst = 1'b0;
    #1;
    chk("g_ready_after", 32'(in_ready), 1);
    push(r2, 1'b0);
    tick();
    tick();
    chk("g_resume_en", 32'(key_en), 1);
    chk("g_resume_sel", 32'(key_sel), 32'(r2));
    pulse_done();
    wait_idle(n);
    chk("g_gap_len", n, CG);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
